// File: rtl/id_ex_stage_if.sv
// Decode-to-execute stage bus: decode handshake, forwarding sources and the
// execute-side handshake, bundled with master (decode/execute side) and slave (stage) views.
interface id_ex_stage_if #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 4,
    parameter int CTRL_W = 8
) ();
    // Handshake: a transfer happens on a rising edge where valid && ready are both 1.
    // A producer holds valid and its payload stable until the transfer; ready may
    // depend combinationally on the consumer-side ready but never on valid.
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [ADDR_W-1:0] in_rs1;
    logic [ADDR_W-1:0] in_rs2;
    logic [ADDR_W-1:0] in_rd;
    logic [DATA_W-1:0] in_rd1;
    logic [DATA_W-1:0] in_rd2;
    logic [DATA_W-1:0] in_imm;
    logic              flush;
    logic              exm_we;
    logic [ADDR_W-1:0] exm_rd;
    logic [DATA_W-1:0] exm_data;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [ADDR_W-1:0] out_rd;
    logic [DATA_W-1:0] out_op1;
    logic [DATA_W-1:0] out_op2;
    logic [DATA_W-1:0] out_imm;

    modport master (
        output in_valid, in_ctrl, in_rs1, in_rs2, in_rd, in_rd1, in_rd2, in_imm,
        output flush, exm_we, exm_rd, exm_data, wb_we, wb_rd, wb_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_rd, out_op1, out_op2, out_imm
    );

    modport slave (
        input  in_valid, in_ctrl, in_rs1, in_rs2, in_rd, in_rd1, in_rd2, in_imm,
        input  flush, exm_we, exm_rd, exm_data, wb_we, wb_rd, wb_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_rd, out_op1, out_op2, out_imm
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, flush, and RAW forwarding.
// Define FORWARDING_EN to enable the EX/MEM + MEM/WB forwarding mux and hold-snoop.
module id_ex_stage #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 4,
    parameter int CTRL_W = 8
) (
    input logic          clk,
    input logic          rst,
    id_ex_stage_if.slave bus
);
    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_op2;
    logic [DATA_W-1:0] r_imm;

    logic              w_in_ready;
    logic              w_load;
    logic              w_hold;
    logic [DATA_W-1:0] w_op1;
    logic [DATA_W-1:0] w_op2;

    // Ready is forced low under reset so decode cannot believe a transfer happened.
    assign w_in_ready = rst & (~r_valid | bus.out_ready);
    assign w_load     = bus.in_valid & w_in_ready & ~bus.flush;
    assign w_hold     = r_valid & ~bus.out_ready;

`ifdef FORWARDING_EN
    logic [ADDR_W-1:0] r_rs1;
    logic [ADDR_W-1:0] r_rs2;

    // Register 0 reads as zero; a matching source compares nonzero, so rd=0 writes never forward.
    function automatic logic [DATA_W-1:0] sel_operand(
        input logic [ADDR_W-1:0] rs,
        input logic [DATA_W-1:0] rf_data
    );
        if (rs == '0)
            return '0;
        else if (bus.exm_we && (bus.exm_rd == rs))
            return bus.exm_data;
        else if (bus.wb_we && (bus.wb_rd == rs))
            return bus.wb_data;
        else
            return rf_data;
    endfunction

    assign w_op1 = sel_operand(bus.in_rs1, bus.in_rd1);
    assign w_op2 = sel_operand(bus.in_rs2, bus.in_rd2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rs1 <= '0;
            r_rs2 <= '0;
        end else if (w_load) begin
            r_rs1 <= bus.in_rs1;
            r_rs2 <= bus.in_rs2;
        end
    end
`else
    logic w_unused_fwd;

    assign w_op1 = (bus.in_rs1 == '0) ? '0 : bus.in_rd1;
    assign w_op2 = (bus.in_rs2 == '0) ? '0 : bus.in_rd2;
    assign w_unused_fwd = ^{bus.exm_we, bus.exm_rd, bus.exm_data,
                            bus.wb_we, bus.wb_rd, bus.wb_data, w_hold};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_rd    <= '0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_imm   <= '0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= bus.in_ctrl;
            r_rd    <= bus.in_rd;
            r_op1   <= w_op1;
            r_op2   <= w_op2;
            r_imm   <= bus.in_imm;
        end else if (r_valid && bus.out_ready) begin
            r_valid <= 1'b0;
`ifdef FORWARDING_EN
        end else if (w_hold && bus.wb_we && (bus.wb_rd != '0)) begin
            // A stalled instruction would otherwise miss a writeback that retires under it.
            if (bus.wb_rd == r_rs1) r_op1 <= bus.wb_data;
            if (bus.wb_rd == r_rs2) r_op2 <= bus.wb_data;
`endif
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_valid;
    assign bus.out_ctrl  = r_ctrl;
    assign bus.out_rd    = r_rd;
    assign bus.out_op1   = r_op1;
    assign bus.out_op2   = r_op2;
    assign bus.out_imm   = r_imm;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed test-plan steps, then randomized traffic,
// all checked against a transaction-level reference model.
module tb_id_ex_stage;
    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: what the execute stage should currently be seeing.
    logic        m_valid;
    logic [7:0]  m_ctrl;
    logic [3:0]  m_rd;
    logic [23:0] m_op1;
    logic [23:0] m_op2;
    logic [23:0] m_imm;
    logic [3:0]  m_rs1;
    logic [3:0]  m_rs2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_ctrl = '0; m_rd = '0;
        m_op1 = '0; m_op2 = '0; m_imm = '0; m_rs1 = '0; m_rs2 = '0;
    endtask

    task automatic check_outputs();
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
        chk("out_ctrl", {24'd0, bus.out_ctrl}, {24'd0, m_ctrl});
        chk("out_rd", {28'd0, bus.out_rd}, {28'd0, m_rd});
        chk("out_op1", {8'd0, bus.out_op1}, {8'd0, m_op1});
        chk("out_op2", {8'd0, bus.out_op2}, {8'd0, m_op2});
        chk("out_imm", {8'd0, bus.out_imm}, {8'd0, m_imm});
    endtask

    // Value an instruction reading register rs should see, given the register file word rf.
    function automatic logic [23:0] ref_operand(input logic [3:0] rs, input logic [23:0] rf);
        if (rs == 4'd0) return 24'd0;
`ifdef FORWARDING_EN
        if (bus.exm_we && bus.exm_rd == rs) return bus.exm_data;
        if (bus.wb_we && bus.wb_rd == rs) return bus.wb_data;
`endif
        return rf;
    endfunction

    task automatic drive_idle();
        bus.in_valid = 1'b0; bus.in_ctrl = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
        bus.in_rd = '0; bus.in_rd1 = '0; bus.in_rd2 = '0; bus.in_imm = '0;
        bus.flush = 1'b0; bus.exm_we = 1'b0; bus.exm_rd = '0; bus.exm_data = '0;
        bus.wb_we = 1'b0; bus.wb_rd = '0; bus.wb_data = '0; bus.out_ready = 1'b1;
    endtask

    task automatic send(input logic [3:0] rs1, input logic [23:0] rd1,
                        input logic [3:0] rs2, input logic [23:0] rd2,
                        input logic [3:0] rd, input logic [7:0] ctrl, input logic [23:0] imm);
        bus.in_valid = 1'b1; bus.in_rs1 = rs1; bus.in_rd1 = rd1; bus.in_rs2 = rs2;
        bus.in_rd2 = rd2; bus.in_rd = rd; bus.in_ctrl = ctrl; bus.in_imm = imm;
    endtask

    // One clock: check ready, predict the next state from current inputs, clock, compare.
    task automatic step();
        logic        rdy;
        logic        take;
        logic        n_valid;
        logic [23:0] n_op1;
        logic [23:0] n_op2;
        #2;
        rdy = rst && (!m_valid || bus.out_ready);
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, rdy});
        take    = bus.in_valid && rdy && !bus.flush;
        n_valid = m_valid;
        n_op1   = m_op1;
        n_op2   = m_op2;
        if (!rst) begin
            n_valid = 1'b0;
        end else if (bus.flush) begin
            n_valid = 1'b0;
        end else if (take) begin
            n_valid = 1'b1;
            n_op1   = ref_operand(bus.in_rs1, bus.in_rd1);
            n_op2   = ref_operand(bus.in_rs2, bus.in_rd2);
        end else if (m_valid && bus.out_ready) begin
            n_valid = 1'b0;
        end else if (m_valid) begin
`ifdef FORWARDING_EN
            if (bus.wb_we && bus.wb_rd != 4'd0 && bus.wb_rd == m_rs1) n_op1 = bus.wb_data;
            if (bus.wb_we && bus.wb_rd != 4'd0 && bus.wb_rd == m_rs2) n_op2 = bus.wb_data;
`endif
        end
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            if (take) begin
                m_ctrl = bus.in_ctrl; m_rd = bus.in_rd; m_imm = bus.in_imm;
                m_rs1 = bus.in_rs1; m_rs2 = bus.in_rs2;
            end
            m_valid = n_valid; m_op1 = n_op1; m_op2 = n_op2;
        end
        #1;
        check_outputs();
    endtask

    initial begin
        drive_idle();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
        rst = 1'b1;

        // Basic load, no forwarding sources active
        send(4'd3, 24'h00000A, 4'd4, 24'h00000B, 4'd9, 8'h5C, 24'hFFF123);
        step();
        chk("basic_op1", {8'd0, bus.out_op1}, 32'h00000A);
        chk("basic_op2", {8'd0, bus.out_op2}, 32'h00000B);
        drive_idle();
        step();

        // Forward priority: EX/MEM wins over MEM/WB, then MEM/WB alone
        send(4'd5, 24'h111111, 4'd6, 24'h222222, 4'd1, 8'h01, 24'h000001);
        bus.exm_we = 1'b1; bus.exm_rd = 4'd5; bus.exm_data = 24'hAAAAAA;
        bus.wb_we = 1'b1; bus.wb_rd = 4'd5; bus.wb_data = 24'hBBBBBB;
        step();
`ifdef FORWARDING_EN
        chk("fwd_exm_prio", {8'd0, bus.out_op1}, 32'hAAAAAA);
`else
        chk("fwd_exm_prio", {8'd0, bus.out_op1}, 32'h111111);
`endif
        bus.exm_we = 1'b0;
        step();
`ifdef FORWARDING_EN
        chk("fwd_wb", {8'd0, bus.out_op1}, 32'hBBBBBB);
`else
        chk("fwd_wb", {8'd0, bus.out_op1}, 32'h111111);
`endif

        // Register 0 is never forwarded
        drive_idle();
        send(4'd0, 24'h777777, 4'd0, 24'h888888, 4'd2, 8'h02, 24'h000002);
        bus.exm_we = 1'b1; bus.exm_rd = 4'd0; bus.exm_data = 24'hFFFFFF;
        bus.wb_we = 1'b1; bus.wb_rd = 4'd0; bus.wb_data = 24'hEEEEEE;
        step();
        chk("r0_op1", {8'd0, bus.out_op1}, 32'h0);
        chk("r0_op2", {8'd0, bus.out_op2}, 32'h0);

        // Stall snoop on held rs2, then release and transfer exactly once
        drive_idle();
        send(4'd2, 24'h121212, 4'd7, 24'h555555, 4'd3, 8'h03, 24'h000003);
        step();
        drive_idle();
        bus.out_ready = 1'b0;
        bus.wb_we = 1'b1; bus.wb_rd = 4'd7; bus.wb_data = 24'h0F0F0F;
        step();
`ifdef FORWARDING_EN
        chk("snoop_op2", {8'd0, bus.out_op2}, 32'h0F0F0F);
`else
        chk("snoop_op2", {8'd0, bus.out_op2}, 32'h555555);
`endif
        chk("snoop_valid", {31'd0, bus.out_valid}, 32'd1);
        bus.wb_we = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();

        // Flush with a simultaneous load drops both
        send(4'd1, 24'h0A0A0A, 4'd2, 24'h0B0B0B, 4'd4, 8'h04, 24'h000004);
        step();
        send(4'd3, 24'h0C0C0C, 4'd4, 24'h0D0D0D, 4'd5, 8'h05, 24'h000005);
        bus.flush = 1'b1;
        step();
        chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("flush_keep_op1", {8'd0, bus.out_op1}, 32'h0A0A0A);
        bus.flush = 1'b0;
        step();
        drive_idle();
        step();

        // Reset while holding an instruction
        send(4'd3, 24'h123456, 4'd0, 24'h000000, 4'd6, 8'h06, 24'h000006);
        step();
        drive_idle();
        bus.out_ready = 1'b0;
        step();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_async_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_async_op1", {8'd0, bus.out_op1}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        send(4'd3, 24'h654321, 4'd1, 24'h000111, 4'd7, 8'h07, 24'h000007);
        bus.out_ready = 1'b1;
        step();
        #3;
        rst = 1'b1;
        drive_idle();
        step();

        // Randomized traffic over a small register window so hazards are frequent
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_ctrl   = 8'($urandom);
            bus.in_rs1    = 4'($urandom_range(0, 7));
            bus.in_rs2    = 4'($urandom_range(0, 7));
            bus.in_rd     = 4'($urandom_range(0, 15));
            bus.in_rd1    = 24'($urandom);
            bus.in_rd2    = 24'($urandom);
            bus.in_imm    = 24'($urandom);
            bus.flush     = ($urandom_range(0, 15) == 0);
            bus.exm_we    = ($urandom_range(0, 1) != 0);
            bus.exm_rd    = 4'($urandom_range(0, 7));
            bus.exm_data  = 24'($urandom);
            bus.wb_we     = ($urandom_range(0, 1) != 0);
            bus.wb_rd     = 4'($urandom_range(0, 7));
            bus.wb_data   = 24'($urandom);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
Decode-to-execute pipeline register directly downstream of the 16x24-bit register file. Captures the two read operands (RD1/RD2), their source addresses, destination address, immediate and control word, and presents them to the ALU one cycle later. Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages. Uses a valid/ready handshake with stall and flush support.

Parameters:
DATA_W, 24, operand/data width (matches register file)
ADDR_W, 4, register address width (16 registers)
CTRL_W, 8, opaque control word width (ALU op, mem/wb enables)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-low reset
in_valid  input  1  decode presents a valid instruction
in_ready  output  1  stage can accept this cycle
in_ctrl  input  CTRL_W  control word
in_rs1  input  ADDR_W  source 1 address (drives A1)
in_rs2  input  ADDR_W  source 2 address (drives A2)
in_rd  input  ADDR_W  destination address
in_rd1  input  DATA_W  register file RD1
in_rd2  input  DATA_W  register file RD2
in_imm  input  DATA_W  sign-extended immediate
flush  input  1  kill held and incoming instruction
exm_we  input  1  EX/MEM will write a register
exm_rd  input  ADDR_W  EX/MEM destination
exm_data  input  DATA_W  EX/MEM result
wb_we  input  1  MEM/WB writing register file (WE3)
wb_rd  input  ADDR_W  MEM/WB destination (A3)
wb_data  input  DATA_W  MEM/WB data (WD3)
out_valid  output  1  execute-stage instruction valid
out_ready  input  1  execute stage accepts
out_ctrl  output  CTRL_W  registered control word
out_rd  output  ADDR_W  registered destination
out_op1  output  DATA_W  registered operand 1
out_op2  output  DATA_W  registered operand 2
out_imm  output  DATA_W  registered immediate

Behaviour:
- Reset (rst=0, async): out_valid=0; out_ctrl, out_rd, out_op1, out_op2, out_imm, held rs1/rs2 all 0. Outputs remain 0 while rst=0.
- in_ready = !out_valid || out_ready (combinational; 0 during reset).
- Load: in_valid && in_ready && !flush -> next edge capture all fields, out_valid=1. Latency exactly 1 cycle.
- Drain: out_valid && out_ready && !(in_valid && in_ready) -> out_valid=0; data fields keep last value.
- Hold: out_valid && !out_ready -> all fields held, except snoop below.
- Flush: highest priority; next edge out_valid=0, incoming instruction dropped, data fields unchanged.
- Operand selection at load, per source (rsN, rdN): if rsN==0 -> 0; else if exm_we && exm_rd==rsN -> exm_data; else if wb_we && wb_rd==rsN -> wb_data; else rdN. EX/MEM wins when both match.
- Snoop during hold: if out_valid && !out_ready && wb_we && wb_rd!=0 and wb_rd equals held rs1/rs2, update out_op1/out_op2 with wb_data at that edge. Both operands update if both match.
- Register 0 never forwarded or snooped; exm_rd=0/wb_rd=0 writes ignored.
- No arithmetic; all widths pass through unchanged.

Optional Feature:
FORWARDING_EN: defined -> forwarding mux and hold-snoop as above. Undefined -> op1=in_rd1, op2=in_rd2 (except rsN==0 -> 0), no snoop; exm_*/wb_* inputs unused; hazards resolved by decode stalls.

Test Plan:
- Reset mid-hold: load op1=0x123456, out_ready=0, drop rst -> out_valid=0, out_op1=0 immediately; in_ready=0 while rst=0.
- Basic load: rs1=3, rd1=0x00000A, rs2=4, rd2=0x00000B, no forwarding -> next cycle out_valid=1, op1=0x00000A, op2=0x00000B.
- Forward priority: rs1=5, exm_we=1 exm_rd=5 exm_data=0xAAAAAA, wb_we=1 wb_rd=5 wb_data=0xBBBBBB -> op1=0xAAAAAA; with exm_we=0 -> 0xBBBBBB.
- R0 protection: rs1=0, exm_we=1 exm_rd=0 exm_data=0xFFFFFF -> op1=0x000000.
- Stall snoop: held rs2=7, out_ready=0, wb_we=1 wb_rd=7 wb_data=0x0F0F0F -> op2=0x0F0F0F next edge, out_valid stays 1; release out_ready -> transfer once.
- Flush with simultaneous load: out_valid=1, in_valid=1, out_ready=1, flush=1 -> next cycle out_valid=0; later load proceeds normally.
